// File: rtl/joe_anim_sequencer_if.sv
// Keycode/vsync inputs and animation-select outputs of the Karate Joe sequencer.
// The master modport is the driving side; the slave modport is the sequencer.
interface joe_anim_sequencer_if;
    logic [7:0] keycode;
    logic       vs;
    logic [3:0] frame_id;
    logic       busy;
    logic       anim_start;
    logic       pending;
    logic [7:0] move_count;

    modport master (
        output keycode, vs,
        input  frame_id, busy, anim_start, pending, move_count
    );
    modport slave (
        input  keycode, vs,
        output frame_id, busy, anim_start, pending, move_count
    );
endinterface

// File: rtl/joe_anim_sequencer.sv
// Karate Joe animation sequencer: keycode presses become timed punch/kick frame
// selects, one step per FRAMES_PER_STEP vsync periods, with a one-deep move buffer.
module joe_anim_sequencer #(
    parameter int         FRAMES_PER_STEP = 6,
    parameter logic [7:0] KEY_J           = 8'h04,
    parameter logic [7:0] KEY_K           = 8'h07
) (
    input  logic                 Clk,
    input  logic                 Reset,
    joe_anim_sequencer_if.slave  bus
);

    localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

    // Encodings double as the sprite frame select.
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        PUNCH_1 = 4'd1, PUNCH_2 = 4'd2, PUNCH_3 = 4'd3,
        KICK_1  = 4'd4, KICK_2  = 4'd5, KICK_3  = 4'd6
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    key_q;
    logic          vs_q;
    logic          pend_q, pend_d;
    logic          pend_kick_q, pend_kick_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic [7:0]    count_q, count_d;

    logic press_j, press_k, tick, step_done, completing;

    assign press_j   = (bus.keycode == KEY_J) && (key_q != KEY_J);
    assign press_k   = (bus.keycode == KEY_K) && (key_q != KEY_K);
    assign tick      = vs_q & ~bus.vs;
    assign step_done = tick && (cnt_q == LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_q       <= 8'h00;
            vs_q        <= 1'b1;
            pend_q      <= 1'b0;
            pend_kick_q <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= bus.keycode;
            vs_q        <= bus.vs;
            pend_q      <= pend_d;
            pend_kick_q <= pend_kick_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_kick_d = pend_kick_q;
        completing  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (press_j)      state_d = PUNCH_1;
                else if (press_k) state_d = KICK_1;
            end
            default: begin
                if (tick) cnt_d = step_done ? '0 : cnt_q + CW'(1);
                if (step_done) begin
                    case (state_q)
                        PUNCH_1: state_d = PUNCH_2;
                        PUNCH_2: state_d = PUNCH_3;
                        KICK_1:  state_d = KICK_2;
                        KICK_2:  state_d = KICK_3;
                        default: completing = 1'b1;
                    endcase
                end
                // A fresh press at completion beats the buffered move.
                if (completing) begin
                    pend_d = 1'b0;
                    if (press_j)      state_d = PUNCH_1;
                    else if (press_k) state_d = KICK_1;
                    else if (pend_q)  state_d = pend_kick_q ? KICK_1 : PUNCH_1;
                    else              state_d = IDLE;
                end else if (press_j || press_k) begin
                    pend_d      = 1'b1;
                    pend_kick_d = press_k;
                end
            end
        endcase
        // _1 states are only ever entered from IDLE or an _3 state.
        start_d = ((state_d == PUNCH_1) || (state_d == KICK_1)) &&
                  (state_q != PUNCH_1) && (state_q != KICK_1);
        count_d = (start_d && (count_q != 8'hFF)) ? count_q + 8'd1 : count_q;
        busy_d  = (state_d != IDLE);
    end

    assign bus.frame_id   = state_q;
    assign bus.busy       = busy_q;
    assign bus.anim_start = start_q;
    assign bus.pending    = pend_q;
    assign bus.move_count = count_q;

endmodule

// File: tb/tb_joe_anim_sequencer.sv
// Bench for joe_anim_sequencer with FRAMES_PER_STEP=2 and one vsync tick per 10 clocks;
// every anim_start is matched against a queue of expected {frame_id, move_count}.
module tb_joe_anim_sequencer;

    logic Clk = 1'b0;
    logic Reset;
    int   tests = 0;
    int   fails = 0;
    int   ph    = 0;

    joe_anim_sequencer_if bus ();

    joe_anim_sequencer #(.FRAMES_PER_STEP(2), .KEY_J(8'h04), .KEY_K(8'h07)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] frame;
        logic [7:0] count;
    } start_t;
    start_t sb[$];

    typedef struct {
        logic [7:0] key;
        int         n;
        logic [3:0] frame;
        logic       busy;
        logic       pend;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: vsync low on phase 9 gives one falling edge per 10 clocks.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            bus.vs = (ph == 9) ? 1'b0 : 1'b1;
            ph = (ph + 1) % 10;
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic sync_phase();
        while (ph != 0) step(1);
    endtask

    task automatic expect_start(input logic [3:0] f, input int c);
        start_t s;
        s.frame = f;
        s.count = (c > 255) ? 8'hFF : 8'(c);
        sb.push_back(s);
    endtask

    // Scoreboard monitor: each anim_start pulse must match the oldest expected start.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (!Reset && bus.anim_start) begin
                if (sb.size() == 0) begin
                    chk("unexpected_anim_start", 1, 0);
                end else begin
                    start_t s;
                    s = sb.pop_front();
                    chk("start_frame", int'(bus.frame_id), int'(s.frame));
                    chk("start_count", int'(bus.move_count), int'(s.count));
                end
            end
        end
    end

    initial begin
        vt[0] = '{8'h04,   1, 4'd1, 1'b1, 1'b0};
        vt[1] = '{8'h04,  18, 4'd1, 1'b1, 1'b0};
        vt[2] = '{8'h04,   1, 4'd2, 1'b1, 1'b0};
        vt[3] = '{8'h04,  19, 4'd2, 1'b1, 1'b0};
        vt[4] = '{8'h04,   1, 4'd3, 1'b1, 1'b0};
        vt[5] = '{8'h04,  19, 4'd3, 1'b1, 1'b0};
        vt[6] = '{8'h04,   1, 4'd0, 1'b0, 1'b0};
        vt[7] = '{8'h04, 140, 4'd0, 1'b0, 1'b0};
        vt[8] = '{8'h00,   5, 4'd0, 1'b0, 1'b0};
        vt[9] = '{8'h00,   5, 4'd0, 1'b0, 1'b0};

        bus.keycode = 8'h00;
        bus.vs      = 1'b1;
        Reset       = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("reset_frame", int'(bus.frame_id), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_count", int'(bus.move_count), 0);
        chk("reset_pending", int'(bus.pending), 0);
        chk("reset_start", int'(bus.anim_start), 0);

        // Held J: one full punch, no retrigger.
        expect_start(4'd1, 1);
        for (int i = 0; i < 10; i++) begin
            bus.keycode = vt[i].key;
            step(vt[i].n);
            chk($sformatf("vec%0d_frame", i), int'(bus.frame_id), int'(vt[i].frame));
            chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vt[i].busy));
            chk($sformatf("vec%0d_pend", i), int'(bus.pending), int'(vt[i].pend));
        end
        chk("hold_count", int'(bus.move_count), 1);
        sync_phase();

        // K pressed during PUNCH_2 plays right after PUNCH_3.
        bus.keycode = 8'h04; expect_start(4'd1, 2); step(1);
        step(19);
        chk("p2_frame", int'(bus.frame_id), 2);
        bus.keycode = 8'h07; expect_start(4'd4, 3); step(1);
        chk("p2_pending", int'(bus.pending), 1);
        step(38);
        chk("p3_frame", int'(bus.frame_id), 3);
        chk("p3_pending", int'(bus.pending), 1);
        step(1);
        chk("b2b_frame", int'(bus.frame_id), 4);
        chk("b2b_pending", int'(bus.pending), 0);
        chk("b2b_busy", int'(bus.busy), 1);
        step(60);
        chk("kick_done_frame", int'(bus.frame_id), 0);
        bus.keycode = 8'h00;
        sync_phase();

        // J, release, J, release, K during PUNCH_1: K overwrites the buffer.
        bus.keycode = 8'h04; expect_start(4'd1, 4); step(1);
        bus.keycode = 8'h00; step(1);
        bus.keycode = 8'h04; step(1);
        chk("buf_j_pending", int'(bus.pending), 1);
        bus.keycode = 8'h00; step(1);
        bus.keycode = 8'h07; expect_start(4'd4, 5); step(1);
        step(55);
        chk("buf_k_frame", int'(bus.frame_id), 4);
        chk("buf_k_pending", int'(bus.pending), 0);
        step(60);
        chk("buf_k_idle", int'(bus.frame_id), 0);
        bus.keycode = 8'h00;
        sync_phase();

        // K on the completion tick beats a buffered punch.
        bus.keycode = 8'h04; expect_start(4'd1, 6); step(1);
        bus.keycode = 8'h00; step(1);
        bus.keycode = 8'h04; step(1);
        bus.keycode = 8'h00; step(1);
        step(55);
        chk("pre_done_pending", int'(bus.pending), 1);
        chk("pre_done_frame", int'(bus.frame_id), 3);
        bus.keycode = 8'h07; expect_start(4'd4, 7); step(1);
        chk("newest_frame", int'(bus.frame_id), 4);
        chk("newest_pending", int'(bus.pending), 0);

        // Reset during KICK_2 with a move buffered.
        step(24);
        bus.keycode = 8'h00; step(1);
        bus.keycode = 8'h04; step(1);
        chk("k2_frame", int'(bus.frame_id), 5);
        chk("k2_pending", int'(bus.pending), 1);
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_frame", int'(bus.frame_id), 0);
        chk("async_rst_pending", int'(bus.pending), 0);
        chk("async_rst_count", int'(bus.move_count), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        chk("sb_empty_at_reset", sb.size(), 0);
        sb.delete();
        @(negedge Clk);
        bus.keycode = 8'h00;
        bus.vs      = 1'b1;
        ph          = 0;
        Reset       = 1'b0;
        step(3);
        chk("post_rst_frame", int'(bus.frame_id), 0);

        // 300 moves: move_count saturates at 255.
        sync_phase();
        for (int i = 1; i <= 300; i++) begin
            bus.keycode = 8'h04; expect_start(4'd1, i); step(1);
            bus.keycode = 8'h00; step(59);
        end
        chk("sat_count", int'(bus.move_count), 255);
        chk("sat_idle", int'(bus.busy), 0);
        chk("sb_empty_end", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
